rl_fifo_1r1w_ctrl: RTL and testbench
====================================

// Module: rl_fifo_1r1w_ctrl
// PURPOSE
//  Synchronous FWFT FIFO controller that drives an external 1R1W RAM block (rl_ram_1r1w, 1-cycle read latency,
//  write-first bypass on same-address read/write). Owns write/read pointers, occupancy and a 2-entry output buffer
//  so the consumer sees a ready/valid stream at full throughput. Sits directly upstream of the RAM; RAM instantiated by parent.
// PARAMETERS
//  ABITS   10   RAM address bits; RAM depth DEPTH = 2**ABITS
//  DBITS   32   data width
// PORTS
//  clk_i        in   1               clock, all logic on rising edge
//  rst_i        in   1               asynchronous reset, active-high
//  flush_i      in   1               synchronous clear of all FIFO contents
//  push_i       in   1               write request, wdata_i accepted when push_i & ~full_o
//  wdata_i      in   DBITS           write data
//  full_o       out  1               RAM storage full, push ignored
//  rvalid_o     out  1               rdata_o holds FIFO head
//  rdata_o      out  DBITS           head data
//  rready_i     in   1               consumer accepts head when rvalid_o & rready_i
//  count_o      out  ABITS+2         total entries held (RAM + read in flight + output buffer), max DEPTH+2
//  ram_waddr_o  out  ABITS           RAM write address (= wptr)
//  ram_din_o    out  DBITS           RAM write data (= wdata_i)
//  ram_we_o     out  1               RAM write enable
//  ram_be_o     out  (DBITS+7)/8     RAM byte enables, constant all-ones
//  ram_raddr_o  out  ABITS           RAM read address (= rptr)
//  ram_re_o     out  1               RAM read enable (prefetch)
//  ram_dout_i   in   DBITS           RAM read data, valid the cycle after ram_re_o
// BEHAVIOUR
//  Reset: wptr=rptr=0, ram_cnt=0, inflight=0, ob empty; full_o=0, rvalid_o=0, count_o=0, ram_we_o=0, ram_re_o=0, rdata_o=0.
//  Write: wr = push_i & ~full_o; ram_we_o = wr; wptr += 1 mod DEPTH on wr (wraps DEPTH-1 -> 0). push while full dropped.
//  full_o = (ram_cnt == DEPTH); ram_cnt width ABITS+1. Total capacity DEPTH+2.
//  Prefetch: rd = (ram_cnt != 0 | wr) & (ob_cnt + inflight - pop < 2); ram_re_o = rd; rptr += 1 mod DEPTH on rd.
//   ram_cnt != 0 false but wr true -> read same address as write this cycle; relies on RAM write-first bypass.
//  ram_cnt next = ram_cnt + wr - rd. inflight next = rd. On inflight, ram_dout_i captured into ob (2-entry FIFO) at edge.
//  Output: pop = rvalid_o & rready_i; rvalid_o = (ob_cnt != 0); rdata_o = ob head, registered (no combinational RAM path).
//  Latency: push at cycle N into empty FIFO -> rvalid_o=1 with that data from cycle N+2. Sustained 1 push + 1 pop/cycle.
//  Simultaneous push & pop at full: pop frees ob slot, prefetch frees RAM slot; full_o falls next cycle, never same cycle.
//  count_o next = count_o + wr - pop; ordering strictly FIFO across wrap-around.
//  flush_i: next cycle identical to reset state; in-flight RAM read data discarded; push/pop in flush cycle ignored.
//  rst_i mid-operation: immediate clear (async); RAM contents not cleared, pointers make them unreachable.
//  rvalid_o, once high, stays high with stable rdata_o until pop (AXI-style stability), except on flush/reset.
// CONFIGURATION
//  RL_FIFO_ERR_FLAGS_EN defined: adds ports ovf_o (out,1) and unf_o (out,1), sticky; ovf_o set on push_i & full_o,
//   unf_o set on rready_i & ~rvalid_o; both cleared only by rst_i or flush_i; reset value 0.
//  Not defined: ports absent, overflow pushes silently dropped, rready_i without rvalid_o ignored.
// TESTING (bench instantiates rl_ram_1r1w GENERIC, ABITS=3, DBITS=32)
//  1 reset: rst_i pulse mid-stream -> all outputs 0 asynchronously, count_o=0, next push 0xA5 appears at rdata_o 2 cycles later.
//  2 latency: single push 0x11 at cycle N, rready_i=1 -> rvalid_o=1 at N+2 only, count_o 1 at N+1, 0 after pop.
//  3 fill: 12 pushes 0..11, rready_i=0 -> full_o=1 after 10th accept, count_o=10, pushes 10,11 dropped; drain reads 0..9 in order.
//  4 throughput/wrap: continuous push+pop 40 words, rready_i=1 -> one word/cycle after 2-cycle fill, pointers wrap 5x, order intact.
//  5 backpressure: random rready_i 50% with random push -> no loss/duplication, rdata_o stable while rvalid_o & ~rready_i.
//  6 flush: 5 entries held, read in flight, flush_i=1 -> next cycle rvalid_o=0, count_o=0; with _EN, push at full sets ovf_o=1 until flush.

Source files
------------

// File: rtl/rl_fifo_1r1w_ctrl.sv
// rtl/rl_fifo_1r1w_ctrl.sv - FWFT FIFO controller for an external 1R1W RAM; optional sticky error flags via RL_FIFO_ERR_FLAGS_EN
module rl_fifo_1r1w_ctrl #(
  parameter int ABITS = 10,
  parameter int DBITS = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 push_i,
  input  logic [DBITS-1:0]     wdata_i,
  output logic                 full_o,
  output logic                 rvalid_o,
  output logic [DBITS-1:0]     rdata_o,
  input  logic                 rready_i,
  output logic [ABITS+1:0]     count_o,
  output logic [ABITS-1:0]     ram_waddr_o,
  output logic [DBITS-1:0]     ram_din_o,
  output logic                 ram_we_o,
  output logic [(DBITS+7)/8-1:0] ram_be_o,
  output logic [ABITS-1:0]     ram_raddr_o,
  output logic                 ram_re_o,
`ifdef RL_FIFO_ERR_FLAGS_EN
  output logic                 ovf_o,
  output logic                 unf_o,
`endif
  input  logic [DBITS-1:0]     ram_dout_i
);

  logic [ABITS-1:0] wptr;
  logic [ABITS-1:0] rptr;
  logic [ABITS:0]   ram_cnt;
  logic             inflight;
  logic [1:0]       ob_cnt;
  logic [DBITS-1:0] ob0;
  logic [DBITS-1:0] ob1;
  logic [ABITS+1:0] count_q;

  logic             wr;
  logic             rd;
  logic             pop;
  logic [2:0]       occ_after_pop;
  logic [1:0]       ob_cnt_n;
  logic [DBITS-1:0] ob0_n;
  logic [DBITS-1:0] ob1_n;

  // ram_cnt never exceeds DEPTH = 2**ABITS, so its MSB alone marks "RAM full"
  assign full_o   = ram_cnt[ABITS];
  assign rvalid_o = (ob_cnt != 2'd0);
  assign rdata_o  = ob0;
  assign count_o  = count_q;

  // Flush and reset both suppress any transfer so the following cycle starts clean
  assign pop = rvalid_o & rready_i & ~flush_i & ~rst_i;
  assign wr  = push_i & ~full_o & ~flush_i & ~rst_i;

  // Prefetch whenever the output buffer plus the read in flight would otherwise drop below two;
  // with an empty RAM a same-cycle write is read back through the RAM's write-first bypass
  always_comb begin
    occ_after_pop = {1'b0, ob_cnt} + {2'b00, inflight} - {2'b00, pop};
    rd = ((ram_cnt != '0) | wr) & (occ_after_pop < 3'd2) & ~flush_i & ~rst_i;
  end

  assign ram_waddr_o = wptr;
  assign ram_din_o   = wdata_i;
  assign ram_we_o    = wr;
  assign ram_be_o    = '1;
  assign ram_raddr_o = rptr;
  assign ram_re_o    = rd;

  // Output buffer next state: pop shifts the head out, then returning RAM data fills the next free slot
  always_comb begin
    ob0_n    = ob0;
    ob1_n    = ob1;
    ob_cnt_n = ob_cnt;
    if (pop) begin
      ob0_n    = ob1;
      ob_cnt_n = ob_cnt - 2'd1;
    end
    if (inflight) begin
      if (ob_cnt_n == 2'd0) begin
        ob0_n = ram_dout_i;
      end else begin
        ob1_n = ram_dout_i;
      end
      ob_cnt_n = ob_cnt_n + 2'd1;
    end
  end

  // Pointers, occupancy counters and the output buffer; flush returns everything to the reset state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr     <= '0;
      rptr     <= '0;
      ram_cnt  <= '0;
      inflight <= 1'b0;
      ob_cnt   <= 2'd0;
      ob0      <= '0;
      ob1      <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wptr     <= '0;
      rptr     <= '0;
      ram_cnt  <= '0;
      inflight <= 1'b0;
      ob_cnt   <= 2'd0;
      ob0      <= '0;
      ob1      <= '0;
      count_q  <= '0;
    end else begin
      if (wr) begin
        wptr <= wptr + ABITS'(1);
      end
      if (rd) begin
        rptr <= rptr + ABITS'(1);
      end
      ram_cnt  <= ram_cnt + (ABITS+1)'(wr) - (ABITS+1)'(rd);
      inflight <= rd;
      ob_cnt   <= ob_cnt_n;
      ob0      <= ob0_n;
      ob1      <= ob1_n;
      count_q  <= count_q + (ABITS+2)'(wr) - (ABITS+2)'(pop);
    end
  end

`ifdef RL_FIFO_ERR_FLAGS_EN
  // Sticky overflow/underflow flags, cleared only by reset or flush
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_o <= 1'b0;
      unf_o <= 1'b0;
    end else if (flush_i) begin
      ovf_o <= 1'b0;
      unf_o <= 1'b0;
    end else begin
      if (push_i & full_o) begin
        ovf_o <= 1'b1;
      end
      if (rready_i & ~rvalid_o) begin
        unf_o <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rl_fifo_1r1w_ctrl.sv
// tb/tb_rl_fifo_1r1w_ctrl.sv - self-checking bench for rl_fifo_1r1w_ctrl with a behavioural write-first 1R1W RAM
module tb_rl_fifo_1r1w_ctrl;

  localparam int ABITS = 3;
  localparam int DBITS = 32;
  localparam int DEPTH = 1 << ABITS;
  localparam int CAP   = DEPTH + 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              push = 1'b0;
  logic [DBITS-1:0]  wdata = '0;
  logic              rready = 1'b0;
  logic              full;
  logic              rvalid;
  logic [DBITS-1:0]  rdata;
  logic [ABITS+1:0]  count;
  logic [ABITS-1:0]  ram_waddr;
  logic [DBITS-1:0]  ram_din;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [ABITS-1:0]  ram_raddr;
  logic              ram_re;
  logic [DBITS-1:0]  ram_dout;
`ifdef RL_FIFO_ERR_FLAGS_EN
  logic              ovf;
  logic              unf;
`endif

  always #5 clk = ~clk;

  rl_fifo_1r1w_ctrl #(.ABITS(ABITS), .DBITS(DBITS)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .push_i(push), .wdata_i(wdata),
    .full_o(full), .rvalid_o(rvalid), .rdata_o(rdata), .rready_i(rready), .count_o(count),
    .ram_waddr_o(ram_waddr), .ram_din_o(ram_din), .ram_we_o(ram_we), .ram_be_o(ram_be),
    .ram_raddr_o(ram_raddr), .ram_re_o(ram_re),
`ifdef RL_FIFO_ERR_FLAGS_EN
    .ovf_o(ovf), .unf_o(unf),
`endif
    .ram_dout_i(ram_dout)
  );

  // Behavioural 1R1W RAM, 1-cycle read latency, write-first on same-address collision
  logic [DBITS-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_re) ram_dout <= (ram_we && ram_waddr == ram_raddr) ? ram_din : mem[ram_raddr];
    if (ram_we) mem[ram_waddr] <= ram_din;
  end

  // Reference model: a queue of accepted words, each visible two cycles after its push
  logic [DBITS-1:0] mq_d[$];
  int               mq_t[$];
  int               cyc = 0;
  logic             m_ovf = 1'b0;
  logic             m_unf = 1'b0;
  logic             hold_prev = 1'b0;
  logic [DBITS-1:0] hold_data = '0;

  function automatic logic m_valid();
    return (mq_d.size() > 0) && (mq_t[0] + 2 <= cyc);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      mq_d.delete();
      mq_t.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      hold_prev = 1'b0;
    end else begin
      logic ev;
      logic mfull;
      ev = m_valid();
      mfull = (mq_d.size() == CAP);
      hold_prev = ev & ~rready;
      hold_data = ev ? mq_d[0] : '0;
      if (push && mfull) m_ovf = 1'b1;
      if (rready && !ev) m_unf = 1'b1;
      if (ev && rready) begin
        void'(mq_d.pop_front());
        void'(mq_t.pop_front());
      end
      if (push && !mfull) begin
        mq_d.push_back(wdata);
        mq_t.push_back(cyc);
      end
    end
    cyc++;
  end

  // Hand-computed expectations posted by the stimulus, checked by the compare process
  typedef struct {
    string            name;
    logic [DBITS-1:0] act;
    logic [DBITS-1:0] exp;
  } lit_t;
  lit_t lit_q[$];

  task automatic lit(input string n, input logic [DBITS-1:0] a, input logic [DBITS-1:0] e);
    lit_t l;
    l.name = n; l.act = a; l.exp = e;
    lit_q.push_back(l);
  endtask

  int vectors = 0;
  int miscompares = 0;

  task automatic cmp(input string n, input logic [DBITS-1:0] a, input logic [DBITS-1:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", n, a, e, $time);
    end
  endtask

  // Single compare process: literal expectations plus per-cycle model comparison
  always @(negedge clk) begin
    while (lit_q.size() > 0) begin
      lit_t l;
      l = lit_q.pop_front();
      cmp(l.name, l.act, l.exp);
    end
    if (!rst) begin
      logic ev;
      ev = m_valid();
      cmp("count_o", 32'(count), 32'(mq_d.size()));
      cmp("full_o", 32'(full), 32'(mq_d.size() == CAP));
      cmp("rvalid_o", 32'(rvalid), 32'(ev));
      if (ev) cmp("rdata_o", rdata, mq_d[0]);
      if (hold_prev) cmp("rdata_stable", rdata, hold_data);
`ifdef RL_FIFO_ERR_FLAGS_EN
      cmp("ovf_o", 32'(ovf), 32'(m_ovf));
      cmp("unf_o", 32'(unf), 32'(m_unf));
`endif
    end
  end

  task automatic drive(input logic p, input logic [DBITS-1:0] d, input logic r, input logic f);
    push = p; wdata = d; rready = r; flush = f;
    @(negedge clk);
  endtask

  initial begin
    logic [DBITS-1:0] got[$];
    int first_v;
    int last_v;

    repeat (2) @(negedge clk);
    lit("reset_count", 32'(count), 0);
    lit("reset_rvalid", 32'(rvalid), 0);
    lit("reset_rdata", rdata, 0);
    lit("reset_we_re", {30'd0, ram_we, ram_re}, 0);
    lit("ram_be", 32'(ram_be), 32'hF);
    #2 rst = 1'b0;

    // latency: single push with rready held high
    drive(1, 32'h11, 1, 0);
    lit("lat_count_n1", 32'(count), 1);
    lit("lat_rvalid_n1", 32'(rvalid), 0);
    drive(0, 0, 1, 0);
    lit("lat_rvalid_n2", 32'(rvalid), 1);
    lit("lat_rdata_n2", rdata, 32'h11);
    drive(0, 0, 1, 0);
    lit("lat_count_after_pop", 32'(count), 0);
    lit("lat_rvalid_after_pop", 32'(rvalid), 0);

    // fill beyond capacity with no consumer
    for (int i = 0; i < 12; i++) drive(1, i, 0, 0);
    drive(0, 0, 0, 0);
    lit("fill_full", 32'(full), 1);
    lit("fill_count", 32'(count), 10);
    got.delete();
    for (int c = 0; c < 30; c++) begin
      if (rvalid) got.push_back(rdata);
      drive(0, 0, 1, 0);
    end
    lit("fill_drain_n", got.size(), 10);
    for (int i = 0; i < 10 && i < got.size(); i++) lit("fill_drain_data", got[i], i);

    // sustained push+pop, pointers wrap five times
    got.delete();
    first_v = -1;
    last_v = -1;
    for (int c = 0; c < 44; c++) begin
      drive(c < 40, 100 + c, 1, 0);
      if (rvalid) begin
        got.push_back(rdata);
        if (first_v < 0) first_v = c;
        last_v = c;
      end
    end
    lit("tput_first", first_v, 1);
    lit("tput_span", last_v - first_v, 39);
    lit("tput_n", got.size(), 40);
    for (int i = 0; i < 40 && i < got.size(); i++) lit("tput_data", got[i], 100 + i);

    // random push and backpressure, checked by the model every cycle
    for (int c = 0; c < 200; c++) drive(1'($urandom % 2), $urandom, 1'($urandom % 2), 0);
    for (int c = 0; c < 20; c++) drive(0, 0, 1, 0);
    lit("rand_drained", 32'(count), 0);

    // flush with a RAM read in flight and a push/pop in the flush cycle
    for (int i = 0; i < 5; i++) drive(1, 200 + i, 0, 0);
    drive(0, 0, 1, 0);
    drive(1, 32'hDEAD, 1, 1);
    lit("flush_rvalid", 32'(rvalid), 0);
    lit("flush_count", 32'(count), 0);
    lit("flush_rdata", rdata, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    lit("flush_no_ghost", 32'(rvalid), 0);

    // overflow at full, then flush
    for (int i = 0; i < 11; i++) drive(1, 300 + i, 0, 0);
    for (int c = 0; c < 3; c++) drive(0, 0, 0, 0);
    lit("ovf_count", 32'(count), 10);
    lit("ovf_head", rdata, 300);
`ifdef RL_FIFO_ERR_FLAGS_EN
    lit("ovf_sticky", 32'(ovf), 1);
`endif
    drive(0, 0, 0, 1);
`ifdef RL_FIFO_ERR_FLAGS_EN
    lit("ovf_cleared", 32'(ovf), 0);
`endif

    // asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) drive(1, 400 + i, 0, 0);
    #2 rst = 1'b1;
    #1;
    lit("arst_count", 32'(count), 0);
    lit("arst_rvalid", 32'(rvalid), 0);
    lit("arst_rdata", rdata, 0);
    lit("arst_full", 32'(full), 0);
    @(negedge clk);
    #2 rst = 1'b0;
    drive(1, 32'hA5, 0, 0);
    drive(0, 0, 0, 0);
    lit("arst_next_rvalid", 32'(rvalid), 1);
    lit("arst_next_rdata", rdata, 32'hA5);
    drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
